// File: rtl/fop_sweep_ctrl.sv
// Sweep sequencer for the three fop implementations: walks every input code,
// cross-checks the three results and tallies the true minterms.
module fop_sweep_ctrl #(
    parameter int N        = 4,
    parameter int EXP_ONES = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         res_g,
    input  logic         res_d,
    input  logic         res_b,
    output logic [N-1:0] vec,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   ones_cnt,
    output logic         err,
    output logic [N-1:0] first_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N-1:0] LAST_CODE = {N{1'b1}};
    localparam logic [N:0]   EXP_CNT   = (N+1)'(EXP_ONES);

    state_t       state, state_n;
    logic [N-1:0] vec_n;
    logic [N:0]   ones_n;
    logic         err_n;
    logic [N-1:0] first_err_n;
    logic         pass_n;
    logic         mismatch;

    assign mismatch = (res_g != res_d) || (res_d != res_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec       <= '0;
            ones_cnt  <= '0;
            err       <= 1'b0;
            first_err <= '0;
            pass      <= 1'b0;
        end else begin
            state     <= state_n;
            vec       <= vec_n;
            ones_cnt  <= ones_n;
            err       <= err_n;
            first_err <= first_err_n;
            pass      <= pass_n;
        end
    end

    // The verdict on the last code is taken from the updated tally and error
    // flag so that a mismatch on the final code still fails the sweep.
    always_comb begin
        state_n     = state;
        vec_n       = vec;
        ones_n      = ones_cnt;
        err_n       = err;
        first_err_n = first_err;
        pass_n      = pass;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n     = RUN;
                    vec_n       = '0;
                    ones_n      = '0;
                    err_n       = 1'b0;
                    first_err_n = '0;
                    pass_n      = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                    vec_n   = '0;
                end else begin
                    ones_n = ones_cnt + {{N{1'b0}}, res_b};
                    if (mismatch && !err) begin
                        err_n       = 1'b1;
                        first_err_n = vec;
                    end
                    vec_n = vec + 1'b1;
                    if (vec == LAST_CODE) begin
                        state_n = DONE;
                        pass_n  = !err_n && (ones_n == EXP_CNT);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
